// File: rtl/mor1kx_spr_pkg.sv
// Shared SPR definitions: group indices, address field extraction and the
// initiator FSM state encoding.
package mor1kx_spr_pkg;

  localparam int SPR_ADDR_W   = 16;
  localparam int SPR_DATA_W   = 32;
  localparam int SPR_GROUP_W  = 5;
  localparam int SPR_OFFSET_W = 11;

  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_SYS  = 5'd0;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_DMMU = 5'd1;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_IMMU = 5'd2;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_DC   = 5'd3;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_IC   = 5'd4;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_MAC  = 5'd5;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_DU   = 5'd6;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_PC   = 5'd7;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_PM   = 5'd8;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_PIC  = 5'd9;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_TT   = 5'd10;
  localparam logic [SPR_GROUP_W-1:0] SPR_GRP_FPU  = 5'd11;

  typedef enum logic [1:0] {
    SPR_IDLE = 2'd0,
    SPR_WAIT = 2'd1,
    SPR_RESP = 2'd2
  } spr_state_e;

  function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [SPR_ADDR_W-1:0] addr);
    return addr[15:11];
  endfunction

  function automatic logic [SPR_OFFSET_W-1:0] spr_offset(input logic [SPR_ADDR_W-1:0] addr);
    return addr[10:0];
  endfunction

endpackage

// File: rtl/mor1kx_spr_initiator_if.sv
// SPR initiator bundle: pipeline request/response plus the per-group SPR bus.
interface mor1kx_spr_initiator_if #(
  parameter int NUM_GROUPS = 32
);
  logic                      req_valid_i;
  logic                      req_we_i;
  logic [15:0]               req_addr_i;
  logic [31:0]               req_dat_i;
  logic                      req_ready_o;
  logic                      rsp_valid_o;
  logic [31:0]               rsp_dat_o;
  logic                      rsp_err_o;
  logic [NUM_GROUPS-1:0]     spr_access_o;
  logic                      spr_we_o;
  logic [15:0]               spr_addr_o;
  logic [31:0]               spr_dat_o;
  logic [NUM_GROUPS-1:0]     spr_bus_ack_i;
  logic [32*NUM_GROUPS-1:0]  spr_dat_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_dat_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output spr_access_o, spr_we_o, spr_addr_o, spr_dat_o,
    input  spr_bus_ack_i, spr_dat_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_dat_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  spr_access_o, spr_we_o, spr_addr_o, spr_dat_o,
    output spr_bus_ack_i, spr_dat_i
  );
endinterface

// File: rtl/mor1kx_spr_group_decode.sv
// SPR address to one-hot group decode with a presence flag; groups outside
// NUM_GROUPS or without a responder report not present.
module mor1kx_spr_group_decode
  import mor1kx_spr_pkg::*;
#(
  parameter int          NUM_GROUPS    = 32,
  parameter logic [31:0] GROUP_PRESENT = 32'h0000_0403
) (
  input  logic [SPR_ADDR_W-1:0] addr,
  output logic [NUM_GROUPS-1:0] onehot,
  output logic                  present
);

  logic [SPR_GROUP_W-1:0] grp;

  assign grp = spr_group(addr);

  always_comb begin
    onehot = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      onehot[g] = (int'(grp) == g);
    end
  end

  assign present = (int'(grp) < NUM_GROUPS) && GROUP_PRESENT[grp];

endmodule

// File: rtl/mor1kx_spr_initiator.sv
// SPR bus initiator: one mtspr/mfspr at a time, per-group access strobe,
// single-cycle response. Optional WAIT timeout under MOR1KX_SPR_TIMEOUT_EN.
module mor1kx_spr_initiator
  import mor1kx_spr_pkg::*;
#(
  parameter int          NUM_GROUPS     = 32,
  parameter logic [31:0] GROUP_PRESENT  = 32'h0000_0403,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  mor1kx_spr_initiator_if.master bus
);

  spr_state_e              state_q;
  spr_state_e              state_d;
  logic [NUM_GROUPS-1:0]   sel_q;
  logic                    we_q;
  logic [SPR_ADDR_W-1:0]   addr_q;
  logic [SPR_DATA_W-1:0]   dat_q;
  logic [SPR_DATA_W-1:0]   rsp_dat_q;
  logic                    rsp_err_q;

  logic [NUM_GROUPS-1:0]   dec_onehot;
  logic                    dec_present;
  logic                    accept;
  logic                    ack_hit;
  logic                    timeout_hit;
  logic                    ready;
  logic                    rsp_valid;
  logic [SPR_DATA_W-1:0]   rd_slice;

  mor1kx_spr_group_decode #(
    .NUM_GROUPS    (NUM_GROUPS),
    .GROUP_PRESENT (GROUP_PRESENT)
  ) u_decode (
    .addr    (bus.req_addr_i),
    .onehot  (dec_onehot),
    .present (dec_present)
  );

  // Read-data select from the latched one-hot group
  always_comb begin
    rd_slice = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (sel_q[g]) begin
        rd_slice = rd_slice | bus.spr_dat_i[32*g +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    case (state_q)
      SPR_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) begin
          accept  = 1'b1;
          state_d = dec_present ? SPR_WAIT : SPR_RESP;
        end
      end
      SPR_WAIT: begin
        ack_hit = |(bus.spr_bus_ack_i & sel_q);
        if (ack_hit || timeout_hit) begin
          state_d = SPR_RESP;
        end
      end
      SPR_RESP: begin
        rsp_valid = 1'b1;
        state_d   = SPR_IDLE;
      end
      default: state_d = SPR_IDLE;
    endcase
  end

`ifdef MOR1KX_SPR_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      wait_cnt_q <= '0;
    end else if (state_q == SPR_WAIT && !ack_hit) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // The counter reads N-1 during the Nth WAIT cycle; an ack that cycle still wins
  assign timeout_hit = (state_q == SPR_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign timeout_hit           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SPR_IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q     <= dec_onehot & {NUM_GROUPS{dec_present}};
        we_q      <= bus.req_we_i;
        addr_q    <= bus.req_addr_i;
        dat_q     <= bus.req_dat_i;
        rsp_dat_q <= '0;
        rsp_err_q <= ~dec_present;
      end else if (ack_hit) begin
        rsp_dat_q <= we_q ? '0 : rd_slice;
        rsp_err_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_dat_q <= '0;
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.spr_access_o = (state_q == SPR_WAIT) ? sel_q : '0;
  assign bus.spr_we_o     = (state_q == SPR_WAIT) && we_q;
  assign bus.spr_addr_o   = addr_q;
  assign bus.spr_dat_o    = dat_q;

endmodule

// File: tb/tb_mor1kx_spr_initiator.sv
// Bench for mor1kx_spr_initiator: transaction-timeline model plus directed
// literal checks; covers the timeout branch when MOR1KX_SPR_TIMEOUT_EN is set.
module tb_mor1kx_spr_initiator;

  localparam int          NG   = 32;
  localparam logic [31:0] GP   = 32'h0000_0403;
  localparam int          TO   = 4;
  localparam int          INF  = 1000000;
`ifdef MOR1KX_SPR_TIMEOUT_EN
  localparam bit          TO_EN = 1'b1;
`else
  localparam bit          TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Responder configuration
  bit          ack_en    = 1'b1;
  int          ack_delay = 0;
  logic [31:0] tt_val    = 32'h0;
  logic [31:0] stray_ack = 32'h0;
  int          acc_cnt   = 0;

  mor1kx_spr_initiator_if #(.NUM_GROUPS(NG)) bus ();

  mor1kx_spr_initiator #(
    .NUM_GROUPS     (NG),
    .GROUP_PRESENT  (GP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) acc_cnt <= (|bus.spr_access_o) ? acc_cnt + 1 : 0;

  always_comb begin
    bus.spr_bus_ack_i = stray_ack;
    if (ack_en && acc_cnt >= ack_delay) bus.spr_bus_ack_i = stray_ack | bus.spr_access_o;
  end

  always_comb begin
    bus.spr_dat_i = '0;
    for (int g = 0; g < NG; g++)
      bus.spr_dat_i[32*g +: 32] = (g == 10) ? tt_val : (32'hC0DE_0000 | 32'(g));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one transaction timeline (access window, response cycle, ready cycle)
  int          m_acc_start = 1;
  int          m_acc_end   = 0;
  int          m_rsp_cyc   = -1;
  int          m_ready_cyc = 0;
  int          m_grp       = 0;
  logic        m_we        = 1'b0;
  logic [15:0] m_addr      = 16'h0;
  logic [31:0] m_dat       = 32'h0;
  logic [31:0] m_rdat      = 32'h0;
  logic        m_err       = 1'b0;

  always @(negedge clk) begin
    logic        in_acc;
    logic [31:0] exp_acc;
    int          d;
    int          nacc;
    if (cyc >= 1) begin
      in_acc  = (cyc >= m_acc_start) && (cyc <= m_acc_end);
      exp_acc = in_acc ? (32'h1 << m_grp) : 32'h0;
      check("spr_access", bus.spr_access_o, exp_acc);
      check("spr_we", 32'(bus.spr_we_o), 32'(in_acc && m_we));
      check("req_ready", 32'(bus.req_ready_o), 32'(cyc >= m_ready_cyc));
      check("rsp_valid", 32'(bus.rsp_valid_o), 32'(cyc == m_rsp_cyc));
      check("spr_addr", 32'(bus.spr_addr_o), 32'(m_addr));
      check("spr_dat", bus.spr_dat_o, m_dat);
      if (cyc == m_rsp_cyc) begin
        check("rsp_dat", bus.rsp_dat_o, m_rdat);
        check("rsp_err", 32'(bus.rsp_err_o), 32'(m_err));
      end
    end
    if (rst) begin
      if (m_acc_end > cyc) m_acc_end = cyc;
      if (m_rsp_cyc > cyc) m_rsp_cyc = -1;
      m_ready_cyc = cyc + 1;
      m_addr = 16'h0;
      m_dat  = 32'h0;
      m_we   = 1'b0;
    end else if (bus.req_valid_i && cyc >= m_ready_cyc) begin
      m_grp  = int'(bus.req_addr_i[15:11]);
      m_we   = bus.req_we_i;
      m_addr = bus.req_addr_i;
      m_dat  = bus.req_dat_i;
      if (!GP[m_grp]) begin
        m_acc_start = 1; m_acc_end = 0;
        m_rsp_cyc = cyc + 1; m_ready_cyc = cyc + 2;
        m_err = 1'b1; m_rdat = 32'h0;
      end else begin
        d = ack_en ? ack_delay : INF;
        m_acc_start = cyc + 1;
        if (TO_EN && d > TO - 1) begin
          nacc = TO; m_err = 1'b1; m_rdat = 32'h0;
        end else begin
          nacc = d + 1; m_err = 1'b0;
          m_rdat = m_we ? 32'h0 : ((m_grp == 10) ? tt_val : (32'hC0DE_0000 | 32'(m_grp)));
        end
        if (d == INF && !TO_EN) begin
          m_acc_end = INF; m_rsp_cyc = -1; m_ready_cyc = INF;
        end else begin
          m_acc_end = cyc + nacc; m_rsp_cyc = cyc + nacc + 1; m_ready_cyc = cyc + nacc + 2;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive a request from just after a posedge; returns just after the accepting edge
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] dat);
    bit done;
    done = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_dat_i   = dat;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready_o === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    check("issue_accepted", 32'(done), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit got;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 16'h0;
    bus.req_dat_i   = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(bus.req_ready_o), 32'h1);
    check("rst_access", bus.spr_access_o, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("rst_spr_addr", 32'(bus.spr_addr_o), 32'h0);
    step(); rst = 1'b0;
    step();

    // Write TTMR, combinational ack
    ack_delay = 0;
    issue(1'b1, 16'h5000, 32'h6000_0010);
    @(negedge clk);
    check("ttmr_access", bus.spr_access_o, 32'h0000_0400);
    check("ttmr_we", 32'(bus.spr_we_o), 32'h1);
    check("ttmr_spr_dat", bus.spr_dat_o, 32'h6000_0010);
    check("ttmr_spr_addr", 32'(bus.spr_addr_o), 32'h5000);
    @(negedge clk);
    check("ttmr_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("ttmr_rsp_err", 32'(bus.rsp_err_o), 32'h0);
    check("ttmr_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("ttmr_access_off", bus.spr_access_o, 32'h0);
    step();

    // Read TTCR, ack after 3 extra cycles, stray acks on groups 0 and 9
    ack_delay = 3; tt_val = 32'h0000_1234; stray_ack = 32'h0000_0201;
    issue(1'b0, 16'h5100, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ttcr_access", bus.spr_access_o, 32'h0000_0400);
    end
    @(negedge clk);
    check("ttcr_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("ttcr_rsp_dat", bus.rsp_dat_o, 32'h0000_1234);
    check("ttcr_rsp_err", 32'(bus.rsp_err_o), 32'h0);
    stray_ack = 32'h0;
    step();

    // Absent group 4
    issue(1'b0, 16'h2000, 32'h0);
    @(negedge clk);
    check("absent_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("absent_rsp_err", 32'(bus.rsp_err_o), 32'h1);
    check("absent_rsp_dat", bus.rsp_dat_o, 32'h0);
    check("absent_access", bus.spr_access_o, 32'h0);
    step();

    // Busy: second request (group 1 read) held while the first is in WAIT
    ack_delay = 1; tt_val = 32'hABCD_0001;
    issue(1'b0, 16'h5100, 32'h0);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0;
    bus.req_addr_i = 16'h0805; bus.req_dat_i = 32'h0;
    @(negedge clk);
    check("busy_ready", 32'(bus.req_ready_o), 32'h0);
    issue(1'b0, 16'h0805, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) begin
        got = 1'b1;
        check("busy2_rsp_dat", bus.rsp_dat_o, 32'hC0DE_0001);
      end
    end
    check("busy2_rsp_seen", 32'(got), 32'h1);
    step();

    // No ack from group 10
    ack_en = 1'b0;
    issue(1'b0, 16'h5100, 32'h0);
`ifdef MOR1KX_SPR_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("to_access", bus.spr_access_o, 32'h0000_0400);
    end
    @(negedge clk);
    check("to_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("to_rsp_err", 32'(bus.rsp_err_o), 32'h1);
    check("to_rsp_dat", bus.rsp_dat_o, 32'h0);
    step();
`else
    repeat (120) @(negedge clk);
    check("hold_access", bus.spr_access_o, 32'h0000_0400);
    check("hold_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
`endif

    // Reset in the middle of WAIT
    issue(1'b1, 16'h5000, 32'h1111_2222);
    @(negedge clk);
    check("rw_access", bus.spr_access_o, 32'h0000_0400);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rw_access_off", bus.spr_access_o, 32'h0);
    check("rw_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    check("rw_ready", 32'(bus.req_ready_o), 32'h1);
    repeat (10) @(negedge clk);
    ack_en = 1'b1; ack_delay = 0;
    step();

    // Write to group 1 after reset recovery
    issue(1'b1, 16'h0812, 32'h5A5A_A5A5);
    @(negedge clk);
    check("g1_access", bus.spr_access_o, 32'h0000_0002);
    @(negedge clk);
    check("g1_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    check("g1_rsp_dat", bus.rsp_dat_o, 32'h0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mor1kx_spr_initiator.md
Name: mor1kx_spr_initiator

Overview:
- SPR bus initiator: takes single mtspr/mfspr requests from the pipeline and drives the per-group SPR bus (access/we/addr/dat).
- Waits for the addressed unit's ack, captures read data, and returns one response pulse.
- Counterpart of SPR responders such as the tick timer (group 10), PIC, and debug unit; sits between the CTRL stage and all SPR-group units.
- One transaction in flight at a time.

Parameters:
- NUM_GROUPS, 32, number of SPR groups decoded (group = addr[15:11]).
- GROUP_PRESENT, 32'h0000_0403, bit g = 1 when group g has a responder; absent groups return an error without bus access.
- TIMEOUT_CYCLES, 255, cycles in WAIT before an error response (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  1  request strobe
- req_we_i  in  1  1 = write (mtspr), 0 = read (mfspr)
- req_addr_i  in  16  full SPR address
- req_dat_i  in  32  write data
- req_ready_o  out  1  request accepted when valid & ready
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  32  read data (0 for writes and errors)
- rsp_err_o  out  1  absent group or timeout
- spr_access_o  out  NUM_GROUPS  one-hot per-group access strobe
- spr_we_o  out  1  write enable
- spr_addr_o  out  16  registered address
- spr_dat_o  out  32  registered write data
- spr_bus_ack_i  in  NUM_GROUPS  per-group ack
- spr_dat_i  in  32*NUM_GROUPS  per-group read data, group g at [32g+31:32g]

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, spr_access_o=0, spr_we_o=0, spr_addr_o=0, spr_dat_o=0.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register addr, data and we.
  - If GROUP_PRESENT[group] is set, go to WAIT. Otherwise go to RESP with err=1 and never assert spr_access_o.
- WAIT:
  - req_ready_o=0.
  - spr_access_o[group]=1; spr_we_o, spr_addr_o, spr_dat_o stable.
  - Exactly one access bit is set.
  - When spr_bus_ack_i[group]=1, in the same cycle: capture spr_dat_i slice into rsp_dat_o (forced to 0 on writes), drop spr_access_o/spr_we_o next cycle, go to RESP with err=0.
  - Acks on other groups are ignored.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - No backpressure; req_ready_o=0.
- Latency with a combinational-ack responder:
  - Accept at cycle 0, access at cycle 1, rsp_valid at cycle 2.
  - Minimum 3 cycles between accepted requests.
  - Absent group: rsp_valid at cycle 1.
- spr_addr_o/spr_dat_o hold their last value in IDLE. Only spr_access_o qualifies them.
- Simultaneous req_valid_i while not IDLE: not accepted; requester must hold.
- Reset mid-WAIT: access drops on the next edge and no response is issued.
- Groups >= NUM_GROUPS are treated as absent.

Optional Feature:
- Macro: MOR1KX_SPR_TIMEOUT_EN.
- Defined:
  - 8-bit+ wait counter cleared on WAIT entry, incremented each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: drop access, go to RESP with err=1, rsp_dat_o=0.
  - Ack in the same cycle as reaching the limit wins (err=0).
- Undefined: no counter; WAIT is held indefinitely until ack.

Decomposition:
- Shared package mor1kx_spr_pkg:
  - SPR group-index constants (e.g. TT group 10, PIC group 9).
  - Group/offset field extraction (addr[15:11], addr[10:0]).
  - FSM state encoding.
- Sub-module mor1kx_spr_group_decode:
  - Combinational address -> one-hot group vector plus present flag.
  - Reusable by other SPR consumers.

Test Plan:
- Write TTMR: req addr 16'h5000, we=1, dat 32'h6000_0010; responder acks combinationally.
  - spr_access_o[10]=1 only at cycle 1, spr_we_o=1, spr_dat_o=32'h6000_0010.
  - rsp_valid at cycle 2, err=0, rsp_dat_o=0.
- Read TTCR: addr 16'h5100, we=0; group-10 slice returns 32'h0000_1234 with ack delayed 3 cycles.
  - access held 4 cycles; rsp_valid one cycle later with rsp_dat_o=32'h0000_1234, err=0.
- Absent group: read addr 16'h2000 (group 4, not present).
  - No spr_access_o bit ever set; rsp_valid at cycle 1, err=1, dat=0.
- Busy: second req_valid_i asserted during WAIT.
  - req_ready_o=0 until IDLE; second request issued only after first response.
  - Correct order and data for both.
- Timeout (MOR1KX_SPR_TIMEOUT_EN, TIMEOUT_CYCLES=4): group 10 never acks.
  - access high for 4 cycles, then rsp_valid with err=1.
  - Same test without macro: access held 100+ cycles, no response.
- Reset mid-WAIT: rst=1 for one cycle.
  - Next cycle: spr_access_o=0, rsp_valid_o=0, req_ready_o=1; no stale response afterwards.
